// File: rtl/accelerator_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational signed multiplier among NUM_REQ requesters.
// Stage A registers the winning operands into the multiplier; stage B captures the product with its requester ID.
module accelerator_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DIN0_WIDTH = 32,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 40
) (
    input  logic                               ap_clk,
    input  logic                               ap_rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]      req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]      req_din1,
    output logic signed [DIN0_WIDTH-1:0]       mul_din0,
    output logic signed [DIN1_WIDTH-1:0]       mul_din1,
    input  logic signed [DOUT_WIDTH-1:0]       mul_dout,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [ID_WIDTH-1:0]                rsp_id,
    output logic signed [DOUT_WIDTH-1:0]       rsp_dout
);

    logic signed [DIN0_WIDTH-1:0] din0_arr [NUM_REQ];
    logic signed [DIN1_WIDTH-1:0] din1_arr [NUM_REQ];

    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] ptr_next;
    logic                a_valid;
    logic [ID_WIDTH-1:0] a_id;

    logic                a_advance;
    logic                b_advance;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_WIDTH-1:0] grant_id;
    logic                any_valid;
    logic [ID_WIDTH:0]   rr_sum;
    logic [ID_WIDTH-1:0] rr_idx;
    logic [ID_WIDTH:0]   ptr_inc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign din0_arr[g] = req_din0[g*DIN0_WIDTH +: DIN0_WIDTH];
        assign din1_arr[g] = req_din1[g*DIN1_WIDTH +: DIN1_WIDTH];
    end

    assign b_advance = !rsp_valid || rsp_ready;
    assign a_advance = !a_valid || b_advance;

    // Round-robin search: start at ptr, wrap modulo NUM_REQ, first valid index wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_valid = 1'b0;
        rr_sum    = '0;
        rr_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = {1'b0, ptr} + (ID_WIDTH+1)'(k);
            if (rr_sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[ID_WIDTH-1:0];
            if (!any_valid && req_valid[rr_idx]) begin
                any_valid      = 1'b1;
                grant[rr_idx]  = 1'b1;
                grant_id       = rr_idx;
            end
        end
    end

    always_comb begin
        ptr_inc  = {1'b0, grant_id} + 1'b1;
        ptr_next = ptr_inc[ID_WIDTH-1:0];
        if (ptr_inc == (ID_WIDTH+1)'(NUM_REQ)) begin
            ptr_next = '0;
        end
    end

    // Reset gates the accept so nothing is handed over during the reset cycle.
    assign req_ready = ap_rst ? '0 : (grant & {NUM_REQ{a_advance}});

    // Stage A: operand register feeding the multiplier
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            a_valid  <= 1'b0;
            a_id     <= '0;
            ptr      <= '0;
            mul_din0 <= '0;
            mul_din1 <= '0;
        end else if (a_advance) begin
            a_valid <= any_valid;
            if (any_valid) begin
                a_id     <= grant_id;
                mul_din0 <= din0_arr[grant_id];
                mul_din1 <= din1_arr[grant_id];
                ptr      <= ptr_next;
            end
        end
    end

    // Stage B: result register capturing the combinational product
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_dout  <= '0;
        end else if (b_advance) begin
            rsp_valid <= a_valid;
            if (a_valid) begin
                rsp_id   <= a_id;
                rsp_dout <= mul_dout;
            end
        end
    end

endmodule

// File: tb/tb_accelerator_mul_arbiter.sv
// Randomized and directed bench for accelerator_mul_arbiter against a slot-level reference model.
// The external multiplier is modelled here as a combinational sign-extended product.
module tb_accelerator_mul_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W0 = 32;
    localparam int W1 = 10;
    localparam int WO = 40;

    logic                    ap_clk;
    logic                    ap_rst;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N*W0-1:0]         req_din0;
    logic [N*W1-1:0]         req_din1;
    logic signed [W0-1:0]    mul_din0;
    logic signed [W1-1:0]    mul_din1;
    logic signed [WO-1:0]    mul_dout;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IW-1:0]           rsp_id;
    logic signed [WO-1:0]    rsp_dout;

    logic signed [WO-1:0]    mul_a_ext;
    logic signed [WO-1:0]    mul_b_ext;

    accelerator_mul_arbiter #(
        .NUM_REQ(N), .ID_WIDTH(IW), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_dout(rsp_dout)
    );

    assign mul_a_ext = WO'(mul_din0);
    assign mul_b_ext = WO'(mul_din1);
    assign mul_dout  = mul_a_ext * mul_b_ext;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        bit          v;
        int          id;
        logic [WO-1:0] p;
    } slot_t;

    // Reference model: two pipeline slots plus the round-robin start index.
    slot_t m_a;
    slot_t m_b;
    int    m_ptr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WO-1:0] ref_prod(input logic [W0-1:0] a, input logic [W1-1:0] b);
        logic signed [W0-1:0] sa;
        logic signed [W1-1:0] sb;
        longint p;
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
        return p[WO-1:0];
    endfunction

    task automatic model_reset();
        m_a.v = 0; m_a.id = 0; m_a.p = '0;
        m_b.v = 0; m_b.id = 0; m_b.p = '0;
        m_ptr = 0;
    endtask

    // Drive one cycle (called at a negedge), check, advance model, return at next negedge.
    task automatic step(input logic [N-1:0] v, input logic [N*W0-1:0] d0,
                        input logic [N*W1-1:0] d1, input logic rr);
        bit           b_adv;
        bit           a_adv;
        int           win;
        int           idx;
        logic [N-1:0] exp_ready;
        req_valid = v;
        req_din0  = d0;
        req_din1  = d1;
        rsp_ready = rr;
        #1;
        check_val("rsp_valid", 64'(rsp_valid), 64'(m_b.v));
        if (m_b.v) begin
            check_val("rsp_id", 64'(rsp_id), 64'(m_b.id));
            check_val("rsp_dout", 64'($unsigned(rsp_dout)), 64'(m_b.p));
        end
        b_adv = !m_b.v || rr;
        a_adv = !m_a.v || b_adv;
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (win < 0 && v[idx]) win = idx;
        end
        exp_ready = '0;
        if (a_adv && win >= 0) exp_ready[win] = 1'b1;
        check_val("req_ready", 64'(req_ready), 64'(exp_ready));
        if (b_adv) m_b = m_a;
        if (a_adv) begin
            m_a.v = (win >= 0);
            if (win >= 0) begin
                m_a.id = win;
                m_a.p  = ref_prod(d0[win*W0 +: W0], d1[win*W1 +: W1]);
                m_ptr  = (win + 1) % N;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic do_reset(input logic [N-1:0] v);
        ap_rst    = 1'b1;
        req_valid = v;
        rsp_ready = 1'b0;
        #1;
        check_val("req_ready_in_reset", 64'(req_ready), 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_reset();
        check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("rst_rsp_id", 64'(rsp_id), 64'd0);
        check_val("rst_rsp_dout", 64'($unsigned(rsp_dout)), 64'd0);
        check_val("rst_mul_din0", 64'($unsigned(mul_din0)), 64'd0);
        check_val("rst_mul_din1", 64'($unsigned(mul_din1)), 64'd0);
    endtask

    logic [N*W0-1:0] d0;
    logic [N*W1-1:0] d1;

    task automatic rand_data();
        for (int k = 0; k < N; k++) begin
            d0[k*W0 +: W0] = $urandom();
            d1[k*W1 +: W1] = W1'($urandom());
        end
    endtask

    task automatic put(input int who, input logic [W0-1:0] a, input logic [W1-1:0] b);
        d0[who*W0 +: W0] = a;
        d1[who*W1 +: W1] = b;
    endtask

    initial begin
        ap_rst    = 1'b1;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b0;
        d0 = '0;
        d1 = '0;
        model_reset();
        @(negedge ap_clk);
        do_reset('0);

        // Single request from requester 2
        put(2, -32'sd100000, -10'sd300);
        step(4'b0100, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);
        check_val("single_valid", 64'(rsp_valid), 64'd1);
        check_val("single_id", 64'(rsp_id), 64'd2);
        check_val("single_dout", 64'($unsigned(rsp_dout)), 64'h00_0001_C9C380);
        step(4'b0000, d0, d1, 1'b1);

        // Truncation corners
        put(0, 32'h8000_0000, -10'sd512);
        step(4'b0001, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);
        check_val("trunc_min_dout", 64'($unsigned(rsp_dout)), 64'd0);
        put(1, 32'd1, -10'sd1);
        step(4'b0010, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);
        check_val("trunc_neg1_dout", 64'($unsigned(rsp_dout)), 64'hFF_FFFF_FFFF);
        step(4'b0000, d0, d1, 1'b1);

        // Round-robin with all requesters held valid from reset
        do_reset(4'b1111);
        for (int c = 0; c < 10; c++) begin
            rand_data();
            step(4'b1111, d0, d1, 1'b1);
        end

        // Backpressure with requesters 0 and 1
        do_reset('0);
        rand_data();
        for (int c = 0; c < 7; c++) step(4'b0011, d0, d1, 1'b0);
        for (int c = 0; c < 6; c++) step(4'b0011, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);

        // Mid-operation reset with A and B full, then lowest valid index wins
        rand_data();
        for (int c = 0; c < 3; c++) step(4'b1100, d0, d1, 1'b0);
        do_reset(4'b1010);
        step(4'b1010, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);

        // Sparse requests: 3 alone, idle, then 1 and 3 together
        do_reset('0);
        rand_data();
        step(4'b1000, d0, d1, 1'b1);
        for (int c = 0; c < 3; c++) step(4'b0000, d0, d1, 1'b1);
        step(4'b1010, d0, d1, 1'b1);
        step(4'b1000, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);
        step(4'b0000, d0, d1, 1'b1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rand_data();
            if ($urandom_range(0, 199) == 0) begin
                do_reset(N'($urandom()));
            end else begin
                step(N'($urandom()) & N'($urandom()),
                     d0, d1, ($urandom_range(0, 3) != 0));
            end
        end
        for (int c = 0; c < 4; c++) step(4'b0000, d0, d1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
